// File: rtl/cordic_pkg.sv
// Shared constants and the in-flight tag type for the CORDIC request scheduler.
package cordic_pkg;

    localparam int          CORDIC_W    = 32;
    localparam int          LAT_DEFAULT = 3;
    localparam int          PORT_W      = 8;
    localparam logic [31:0] FP_ONE      = 32'h3F80_0000;

    typedef struct packed {
        logic              vld;
        logic [PORT_W-1:0] port;
    } tag_t;

    // Index width that stays legal for a single-port build.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the last granted port.
module rr_arbiter
    import cordic_pkg::*;
#(
    parameter  int NPORT = 4,
    localparam int IW    = sel_w(NPORT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] req,
    input  logic             upd,
    output logic [NPORT-1:0] grant,
    output logic [IW-1:0]    grant_idx,
    output logic             grant_any
);

    logic [IW-1:0] last_grant;
    logic [IW-1:0] k;

    always_comb begin
        grant     = '0;
        grant_idx = last_grant;
        grant_any = 1'b0;
        k         = '0;
        for (int i = 1; i <= NPORT; i++) begin
            k = IW'((int'(last_grant) + i) % NPORT);
            if (!grant_any && req[k]) begin
                grant_any = 1'b1;
                grant_idx = k;
                grant[k]  = 1'b1;
            end
        end
    end

    // Reset to the last port so port 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant <= IW'(NPORT - 1);
        end else if (upd) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/cordic_sched.sv
// cordic_sched: shares one external CORDIC cosine pipeline among NPORT requesters.
// Define CORDIC_SCHED_PERF_EN to add the perf_ops / perf_stall counters.
module cordic_sched
    import cordic_pkg::*;
#(
    parameter int NPORT = 4,
    parameter int W     = CORDIC_W,
    parameter int LAT   = LAT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NPORT-1:0]   req_valid,
    input  logic [NPORT*W-1:0] req_data,
    output logic [NPORT-1:0]   req_ready,
    output logic [W-1:0]       cordic_dataa,
    input  logic [W-1:0]       cordic_result,
    output logic [NPORT-1:0]   rsp_valid,
    output logic [NPORT*W-1:0] rsp_data,
    input  logic [NPORT-1:0]   rsp_ready
`ifdef CORDIC_SCHED_PERF_EN
    ,
    output logic [31:0]        perf_ops,
    output logic [31:0]        perf_stall
`endif
);

    localparam int IW = sel_w(NPORT);

    logic [NPORT-1:0] busy;
    logic [NPORT-1:0] eligible;
    logic [NPORT-1:0] grant;
    logic [NPORT-1:0] rsp_hs;
    logic [IW-1:0]    grant_idx;
    logic             grant_any;
    logic [W-1:0]     sel_data;
    tag_t             tag_p [LAT];

    // A busy port stays ineligible until its result has been taken.
    assign eligible  = req_valid & ~busy & {NPORT{rst}};
    assign rsp_hs    = rsp_valid & rsp_ready;
    assign req_ready = grant;

    rr_arbiter #(.NPORT(NPORT)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (eligible),
        .upd       (grant_any),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        sel_data = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (grant[p]) sel_data = req_data[p*W +: W];
        end
    end

    // Issue stage: operand register feeding the CORDIC
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy         <= '0;
            cordic_dataa <= '0;
        end else begin
            busy <= (busy & ~rsp_hs) | grant;
            if (grant_any) cordic_dataa <= sel_data;
        end
    end

    // Tag stages: track which port owns each CORDIC slot, no stalls
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) tag_p[i] <= '0;
        end else begin
            tag_p[0] <= '{vld: grant_any, port: PORT_W'(grant_idx)};
            for (int i = 1; i < LAT; i++) tag_p[i] <= tag_p[i-1];
        end
    end

    // Response stage: land the CORDIC output in the owning port's slot
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                if (tag_p[LAT-1].vld && tag_p[LAT-1].port == PORT_W'(p)) begin
                    rsp_valid[p]       <= 1'b1;
                    rsp_data[p*W +: W] <= cordic_result;
                end else if (rsp_hs[p]) begin
                    rsp_valid[p] <= 1'b0;
                end
            end
        end
    end

`ifdef CORDIC_SCHED_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (grant_any) perf_ops <= sat_inc(perf_ops);
            if (|req_valid && !grant_any) perf_stall <= sat_inc(perf_stall);
        end
    end
`endif

endmodule

// File: tb/tb_cordic_sched.sv
// Scoreboard bench for cordic_sched: a round-robin reference model predicts grants and results.
`timescale 1ns/1ps
module tb_cordic_sched;

    localparam int NPORT = 4;
    localparam int W     = 32;
    localparam int LAT   = 3;

    logic               clk       = 1'b0;
    logic               rst       = 1'b0;
    logic [NPORT-1:0]   req_valid = '0;
    logic [NPORT*W-1:0] req_data  = '0;
    logic [NPORT-1:0]   rsp_ready = '0;
    logic [NPORT-1:0]   req_ready;
    logic [NPORT-1:0]   rsp_valid;
    logic [NPORT*W-1:0] rsp_data;
    logic [W-1:0]       cordic_dataa;
    logic [W-1:0]       cordic_result;
`ifdef CORDIC_SCHED_PERF_EN
    logic [31:0]        perf_ops;
    logic [31:0]        perf_stall;
`endif

    always #5 clk = ~clk;

    cordic_sched #(.NPORT(NPORT), .W(W), .LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .cordic_dataa  (cordic_dataa),
        .cordic_result (cordic_result),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_ready     (rsp_ready)
`ifdef CORDIC_SCHED_PERF_EN
        ,
        .perf_ops      (perf_ops),
        .perf_stall    (perf_stall)
`endif
    );

    // External CORDIC stand-in: result appears LAT clocks after the operand is issued.
    logic [W-1:0] cdl [LAT-1];
    always @(posedge clk) begin
        cdl[0] <= cordic_dataa;
        for (int i = 1; i < LAT-1; i++) cdl[i] <= cdl[i-1];
    end
    assign cordic_result = cdl[LAT-2];

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    int          nchk = 0;
    int          nerr = 0;
    int          cyc  = 0;
    logic        rst_seen = 1'b0;
    exp_t        exp_q [NPORT][$];
    bit          m_busy [NPORT];
    bit          m_hold [NPORT];
    logic [31:0] m_held [NPORT];
    int          gcount [NPORT];
    int          m_last = NPORT - 1;
    logic [31:0] m_dataa = '0;
    logic [NPORT-1:0] acc  = '0;
    logic [NPORT-1:0] keep = '0;
    int          m_ops   = 0;
    int          m_stall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // Monitor: reference model plus scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        int          eg;
        int          k;
        exp_t        e;
        logic [NPORT-1:0] exp_ready;
        if (!rst) begin
            check("rst_req_ready", 32'(req_ready), 32'd0);
            if (!rst_seen) begin
                check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
                check("rst_rsp_data", rsp_data[31:0] | rsp_data[63:32] | rsp_data[95:64] | rsp_data[127:96], 32'd0);
                check("rst_dataa", cordic_dataa, 32'd0);
            end
            for (int p = 0; p < NPORT; p++) begin
                exp_q[p].delete();
                m_busy[p] = 0;
                m_hold[p] = 0;
            end
            m_last  = NPORT - 1;
            m_dataa = '0;
            acc     = '0;
            m_ops   = 0;
            m_stall = 0;
        end else begin
            eg = -1;
            for (int i = 1; i <= NPORT; i++) begin
                k = (m_last + i) % NPORT;
                if (eg < 0 && req_valid[k] && !m_busy[k]) eg = k;
            end
            exp_ready = (eg >= 0) ? (NPORT'(1) << eg) : '0;
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("cordic_dataa", cordic_dataa, m_dataa);
            acc = req_valid & req_ready;
            if (eg >= 0) begin
                e.data = req_data[eg*W +: W];
                e.due  = cyc + LAT + 1;
                exp_q[eg].push_back(e);
                m_busy[eg] = 1;
                m_last     = eg;
                m_dataa    = e.data;
                gcount[eg]++;
                m_ops++;
            end else if (|req_valid) begin
                m_stall++;
            end
            for (int p = 0; p < NPORT; p++) begin
                if (rsp_valid[p]) begin
                    if (!m_hold[p]) begin
                        if (exp_q[p].size() == 0) begin
                            check("rsp_unexpected", 32'(rsp_valid[p]), 32'd0);
                        end else begin
                            e = exp_q[p].pop_front();
                            check("rsp_data", rsp_data[p*W +: W], e.data);
                            check("rsp_latency", 32'(cyc), 32'(e.due));
                            m_held[p] = e.data;
                        end
                        m_hold[p] = 1;
                    end else begin
                        check("rsp_stable", rsp_data[p*W +: W], m_held[p]);
                    end
                    if (rsp_ready[p]) begin
                        m_hold[p] = 0;
                        m_busy[p] = 0;
                    end
                end else begin
                    if (m_hold[p]) begin
                        check("rsp_dropped", 32'(rsp_valid[p]), 32'd1);
                        m_hold[p] = 0;
                    end
                    if (exp_q[p].size() > 0 && exp_q[p][0].due <= cyc) begin
                        check("rsp_late", 32'(rsp_valid[p]), 32'd1);
                        void'(exp_q[p].pop_front());
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int p = 0; p < NPORT; p++) begin
            if (acc[p]) begin
                if (keep[p]) req_data[p*W +: W] = $urandom;
                else         req_valid[p] = 1'b0;
            end
        end
    endtask

    task automatic set_req(input int p, input logic [31:0] v);
        req_valid[p]       = 1'b1;
        req_data[p*W +: W] = v;
    endtask

    initial begin
        int g0, g2, guard;
        bit pending;
        repeat (3) step();
        rst = 1'b1;

        // Single transaction on port 0
        rsp_ready = '1;
        set_req(0, 32'h3F00_0000);
        repeat (8) step();

        // All ports contending
        for (int p = 0; p < NPORT; p++) set_req(p, $urandom);
        repeat (10) step();

        // Port 1 held off by its consumer while it keeps requesting
        rsp_ready = 4'b1101;
        keep      = 4'b0010;
        set_req(1, $urandom);
        repeat (10) begin
            step();
            if (cyc > 0) check("bp_ready1", 32'(req_ready[1] & (rsp_valid[1])), 32'd0);
        end
        rsp_ready = '1;
        keep      = '0;
        repeat (10) step();

        // Fairness between ports 0 and 2
        g0 = gcount[0];
        g2 = gcount[2];
        keep = 4'b0101;
        set_req(0, $urandom);
        set_req(2, $urandom);
        repeat (40) step();
        keep = '0;
        repeat (10) step();
        check("fair_p0", 32'(gcount[0] - g0 >= 6), 32'd1);
        check("fair_p2", 32'(gcount[2] - g2 >= 6), 32'd1);

        // Reset while port 3 is in flight
        set_req(3, $urandom);
        step();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        req_valid = '0;
        repeat (8) begin
            step();
            check("rst_flush", 32'(rsp_valid), 32'd0);
        end
        for (int p = 0; p < NPORT; p++) set_req(p, $urandom);
        repeat (10) step();

        // Randomised traffic
        repeat (1500) begin
            for (int p = 0; p < NPORT; p++) begin
                if (!req_valid[p] && ($urandom_range(2) == 0)) set_req(p, $urandom);
            end
            rsp_ready = NPORT'($urandom);
            keep      = NPORT'($urandom);
            step();
        end

        // Drain
        keep      = '0;
        req_valid = '0;
        rsp_ready = '1;
        guard     = 0;
        pending   = 1;
        while (pending && guard < 50) begin
            step();
            guard++;
            pending = (rsp_valid != 0);
            for (int p = 0; p < NPORT; p++) if (exp_q[p].size() > 0) pending = 1;
        end
        check("drain", 32'(pending), 32'd0);

`ifdef CORDIC_SCHED_PERF_EN
        check("perf_ops", perf_ops, 32'(m_ops));
        check("perf_stall", perf_stall, 32'(m_stall));
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/cordic_sched.md
CORDIC_SCHED -- requirements
Module: cordic_sched

Interface
REQ-001 Parameter NPORT, default 4: number of requesters sharing one CORDIC cosine pipeline.
REQ-002 Parameter W, default 32: IEEE-754 single operand/result width.
REQ-003 Parameter LAT, default 3: clocks from cordic_dataa capture to the matching cordic_result.
REQ-004 clk  in  1  sole clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 req_valid  in  NPORT  per-port operand valid.
REQ-007 req_data  in  NPORT*W  per-port float angle; port p occupies bits [p*W+W-1 : p*W].
REQ-008 req_ready  out  NPORT  per-port accept; a transfer occurs when req_valid[p] and req_ready[p] are both high.
REQ-009 cordic_dataa  out  W  operand driven to the shared CORDIC.
REQ-010 cordic_result  in  W  CORDIC float output.
REQ-011 rsp_valid  out  NPORT  per-port result valid.
REQ-012 rsp_data  out  NPORT*W  per-port result, packed like req_data.
REQ-013 rsp_ready  in  NPORT  per-port result accept.

Function
REQ-014 Port p is eligible when req_valid[p]=1 and busy[p]=0; busy[p] is set on grant and cleared when rsp_valid[p]&rsp_ready[p]; at most one outstanding operation per port.
REQ-015 At most one grant per cycle, round-robin: search starts at last_grant+1 mod NPORT; last_grant updates only on a grant.
REQ-016 req_ready is one-hot or zero, combinational from eligibility and the round-robin pointer; req_ready[p] never asserts while busy[p]=1.
REQ-017 On grant, cordic_dataa is registered with the granted operand on the same edge; with no grant it holds its last value.
REQ-018 A tag pipeline of LAT stages carries {valid, port index}; stage 0 loads {grant, granted port} each cycle, no stalls.
REQ-019 When tag stage LAT-1 is valid, cordic_result is captured into rsp_data slot of the tagged port and rsp_valid of that port sets; issue-to-rsp_valid latency is exactly LAT+1 clocks.
REQ-020 rsp_valid[p] holds with stable rsp_data until rsp_ready[p]; busy[p] guarantees no overwrite.
REQ-021 Simultaneous rsp handshake on port p and a new req_valid[p]: busy[p] clears on that edge; the port is eligible the following cycle, never the same cycle.
REQ-022 Back-to-back grants to different ports on consecutive cycles are permitted (throughput 1 op/clk).
REQ-023 Results from different ports may complete in consecutive cycles; each lands only in its own slot.

Reset
REQ-024 While rst=0: req_ready=0, rsp_valid=0, rsp_data=0, cordic_dataa=0, busy=0, all tag valids=0, last_grant=NPORT-1 (port 0 wins first).
REQ-025 Reset mid-operation discards all in-flight tags; CORDIC outputs arriving after reset release produce no rsp_valid.

Configuration
REQ-026 Macro CORDIC_SCHED_PERF_EN: when defined, adds output perf_ops (32 bits, counts grants) and output perf_stall (32 bits, counts cycles with any req_valid high and no grant), both saturating at all-ones and cleared by reset.
REQ-027 Without CORDIC_SCHED_PERF_EN, the ports and counters do not exist; all other behaviour is identical.

Structure
REQ-028 Shared package cordic_pkg holds W, default LAT, the tag struct {valid, port}, and the float constant FP_ONE = 32'h3F80_0000.
REQ-029 The round-robin arbiter is one sub-module, rr_arbiter (NPORT request in, one-hot grant out, pointer-update input).
REQ-030 The CORDIC is instantiated outside this block; cordic_sched has no arithmetic on float data.

Verification (bench models CORDIC as a LAT-deep delay of cordic_dataa, LAT=3)
REQ-031 Single: port 0 sends 32'h3F00_0000 at cycle 0 -> cordic_dataa=32'h3F00_0000 at cycle 1, rsp_valid[0]=1 with that value at cycle 4, no other rsp_valid.
REQ-032 Contention: all 4 ports valid from cycle 0, rsp_ready=1 -> grants in order 0,1,2,3 on cycles 0-3, responses on cycles 4-7 to ports 0-3.
REQ-033 Backpressure: port 1 rsp_ready=0 for 10 cycles, req_valid[1] held -> req_ready[1]=0 throughout; rsp_data[1] stable; one cycle after rsp_ready[1]=1, req_ready[1] may assert.
REQ-034 Fairness: ports 0 and 2 continuously valid, immediate rsp_ready -> grants alternate 0,2,0,2 whenever both are eligible; neither starves.
REQ-035 Reset mid-flight: grant port 3, assert rst=0 at cycle 2 for 1 cycle -> rsp_valid stays 0 for 8 following cycles; port 0 is the next grant.
REQ-036 With CORDIC_SCHED_PERF_EN: 4 grants plus 2 valid-but-blocked cycles -> perf_ops=4, perf_stall=2.
